// File: rtl/tt_um_spi_ram_reader.sv
// tt_um_spi_ram_reader: reads one byte from an external SPI RAM (READ 0x03, mode 0) at address ui_in.
// Optional macro CONT_READ_EN: poll continuously instead of re-reading only when ui_in changes.

module spi_ram_master #(
   parameter int ADDR_BYTES = 1,
   parameter int GAP_CYCLES = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic [7:0] addr_i,
   input  logic       miso_i,
   output logic       idle_o,
   output logic       cs_n_o,
   output logic       sck_o,
   output logic       mosi_o,
   output logic [7:0] data_o
);
   localparam int AW     = 8 * ADDR_BYTES;
   localparam int TX_W   = AW + 16;
   localparam int HALF_N = 2 * TX_W;
   localparam int CNT_W  = $clog2(HALF_N);
   localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_N - 1);
   localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_SHIFT  = 3'd2,
      S_FINISH = 3'd3,
      S_GAP    = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [TX_W-1:0]   tx_q, tx_d;
   logic [7:0]        rx_q, rx_d;
   logic [7:0]        data_q, data_d;
   logic              sck_q, sck_d;
   logic              mosi_q, mosi_d;
   logic              cs_n_q, cs_n_d;
   logic              done_q, done_d;
   logic              done;
   logic [AW-1:0]     addr_field_s;

   assign done         = done_q;
   assign addr_field_s = AW'(addr_i);

   // Next-state and next-output logic; all pins are registered from these values
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      data_d  = data_q;
      sck_d   = 1'b0;
      mosi_d  = 1'b0;
      cs_n_d  = 1'b1;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_START;
               tx_d    = {8'h03, addr_field_s, 8'h00};
               cs_n_d  = 1'b0;
               mosi_d  = tx_d[TX_W-1];
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            state_d = S_SHIFT;
            cnt_d   = '0;
            cs_n_d  = 1'b0;
            sck_d   = 1'b1;
            mosi_d  = mosi_q;
         end
         S_SHIFT: begin
            cs_n_d = 1'b0;
            if (cnt_q == CNT_LAST) begin
               state_d = S_FINISH;
               cs_n_d  = 1'b1;
               data_d  = rx_q;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               // SCK falls here: MISO has been stable for the whole high phase
               if (sck_q) begin
                  sck_d  = 1'b0;
                  rx_d   = {rx_q[6:0], miso_i};
                  tx_d   = {tx_q[TX_W-2:0], 1'b0};
                  mosi_d = tx_q[TX_W-2];
               end else begin
                  sck_d  = 1'b1;
                  mosi_d = mosi_q;
               end
            end
         end
         S_FINISH: begin
            state_d = S_GAP;
         end
         S_GAP: begin
            if (gap_q == '0) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_GAP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (done) begin
         gap_d = GAP_INIT;
      end else if (state_q == S_GAP) begin
         gap_d = gap_q - GAP_W'(1);
      end else begin
         gap_d = gap_q;
      end
   end

   // State and output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         gap_q   <= '0;
         tx_q    <= '0;
         rx_q    <= 8'h00;
         data_q  <= 8'h00;
         sck_q   <= 1'b0;
         mosi_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         data_q  <= data_d;
         sck_q   <= sck_d;
         mosi_q  <= mosi_d;
         cs_n_q  <= cs_n_d;
         done_q  <= done_d;
      end
   end

   assign idle_o = (state_q == S_IDLE);
   assign cs_n_o = cs_n_q;
   assign sck_o  = sck_q;
   assign mosi_o = mosi_q;
   assign data_o = data_q;
endmodule

module tt_um_spi_ram_reader #(
   parameter int ADDR_BYTES = 1,
   parameter int GAP_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);
   logic [1:0] arm_q;
   logic       start_s;
   logic       idle_s;
   logic       cs_n_s;
   logic       sck_s;
   logic       mosi_s;
   logic [7:0] data_s;
   logic       unused_s;

   // Hold off the first START so ui_in presented with reset release is captured
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arm_q <= 2'b00;
      end else begin
         arm_q <= {arm_q[0], 1'b1};
      end
   end

`ifdef CONT_READ_EN
   assign start_s = ena & arm_q[1];
`else
   logic       seen_q;
   logic [7:0] last_q;

   assign start_s = ena & arm_q[1] & (~seen_q | (ui_in != last_q));

   // Remember the address of the most recently started frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen_q <= 1'b0;
         last_q <= 8'h00;
      end else if (idle_s && start_s) begin
         seen_q <= 1'b1;
         last_q <= ui_in;
      end else begin
         seen_q <= seen_q;
         last_q <= last_q;
      end
   end
`endif

   spi_ram_master #(
      .ADDR_BYTES (ADDR_BYTES),
      .GAP_CYCLES (GAP_CYCLES)
   ) spi_if (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .start_i (start_s),
      .addr_i  (ui_in),
      .miso_i  (uio_in[2]),
      .idle_o  (idle_s),
      .cs_n_o  (cs_n_s),
      .sck_o   (sck_s),
      .mosi_o  (mosi_s),
      .data_o  (data_s)
   );

   assign uo_out   = data_s;
   assign uio_out  = {4'b0000, sck_s, 1'b0, mosi_s, cs_n_s};
   assign uio_oe   = 8'b0000_1011;
   assign unused_s = &{1'b0, uio_in[7:3], uio_in[1:0]};
endmodule

// File: tb/tb_tt_um_spi_ram_reader.sv
// Scoreboard bench for tt_um_spi_ram_reader with a behavioural SPI RAM model on the uio pins.
module tb_tt_um_spi_ram_reader;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic [7:0] ui_in = 8'h12;
   logic [7:0] uo_out, uio_out, uio_oe;
   logic       miso = 1'b0;
   wire  [7:0] uio_in = {5'b00000, miso, 2'b00};

   always #5 clk = ~clk;

   tt_um_spi_ram_reader dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
      .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
   );

   wire cs_n = uio_out[0];
   wire mosi = uio_out[1];
   wire sck  = uio_out[3];

   int n_checks = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // RAM model
   logic [7:0]  mem [256];
   int          cyc = 0;
   int          frames = 0;
   int          cur_frame = 0;
   int          cs_fall_cyc = 0;
   int          rises = 0;
   int          total_rises = 0;
   logic [15:0] hdr = 16'h0000;
   logic        rd_mosi_hi = 1'b0;

   always @(posedge clk) cyc++;

   always @(negedge cs_n) begin
      frames++;
      cs_fall_cyc = cyc;
   end

   always @(posedge sck) begin
      if (frames != cur_frame) begin
         cur_frame  = frames;
         rises      = 0;
         hdr        = 16'h0000;
         rd_mosi_hi = 1'b0;
      end
      if (rises < 16) hdr = {hdr[14:0], mosi};
      else if (mosi !== 1'b0) rd_mosi_hi = 1'b1;
      rises++;
      total_rises++;
   end

   always @(negedge sck) begin
      #1;
      if (rises >= 16 && rises < 24) miso = mem[hdr[7:0]][23 - rises];
   end

   // Scoreboard
   typedef struct { logic [7:0] addr; logic [7:0] data; } exp_t;
   exp_t expq[$];
   exp_t e_m;

   always @(posedge clk) begin
      #1;
      check("uio_oe", {24'h0, uio_oe}, 32'h0B);
      check("uio_out_zero_bits", {24'h0, uio_out & 8'hF4}, 32'h0);
      if (dut.spi_if.done === 1'b1) begin
         if (expq.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e_m = expq.pop_front();
            check("uo_out", {24'h0, uo_out}, {24'h0, e_m.data});
            check("cmd_byte", {24'h0, hdr[15:8]}, 32'h03);
            check("addr_byte", {24'h0, hdr[7:0]}, {24'h0, e_m.addr});
            check("sck_rises", rises, 32'd24);
            check("latency", cyc - cs_fall_cyc, 32'd49);
            check("mosi_read_zero", {31'h0, rd_mosi_hi}, 32'd0);
            check("cs_n_finish", {31'h0, cs_n}, 32'd1);
         end
      end
   end

   task automatic wait_idle(input int budget);
      int n = 0;
      while (expq.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      check("done_timeout", expq.size(), 32'd0);
      expq.delete();
      @(posedge clk);
      #2;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
      mem[8'h12] = 8'hA5;
      mem[8'h34] = 8'h5A;
      mem[8'h56] = 8'h3C;

      repeat (3) @(posedge clk);
      #1;
      check("rst_uo_out", {24'h0, uo_out}, 32'h00);
      check("rst_uio_out", {24'h0, uio_out}, 32'h01);
      check("rst_done", {31'h0, dut.spi_if.done}, 32'd0);

      // ena low: nothing happens
      @(negedge clk) rst_n = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      check("ena0_rises", total_rises, 32'd0);
      check("ena0_frames", frames, 32'd0);
      check("ena0_cs_n", {31'h0, cs_n}, 32'd1);
      check("ena0_uo_out", {24'h0, uo_out}, 32'h00);

      // first read
      expq.push_back('{addr: 8'h12, data: 8'hA5});
      ena = 1'b1;
      wait_idle(200);
      check("first_uo_out", {24'h0, uo_out}, 32'hA5);

      // same address: no further frames
      repeat (80) @(posedge clk);
      #1;
      check("no_rerun_frames", frames, 32'd1);
      check("hold_uo_out", {24'h0, uo_out}, 32'hA5);

      // address change mid-frame
      expq.push_back('{addr: 8'h34, data: 8'h5A});
      ui_in = 8'h34;
      repeat (15) @(posedge clk);
      #1;
      check("midframe_cs_n", {31'h0, cs_n}, 32'd0);
      check("midframe_uo_hold", {24'h0, uo_out}, 32'hA5);
      expq.push_back('{addr: 8'h12, data: 8'hA5});
      ui_in = 8'h12;
      wait_idle(400);
      check("change_frames", frames, 32'd3);
      check("change_uo_out", {24'h0, uo_out}, 32'hA5);

      // reset during SHIFT
      ui_in = 8'h56;
      repeat (20) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_cs_n", {31'h0, cs_n}, 32'd1);
      check("arst_sck", {31'h0, sck}, 32'd0);
      check("arst_uo_out", {24'h0, uo_out}, 32'h00);
      check("arst_done", {31'h0, dut.spi_if.done}, 32'd0);
      expq.push_back('{addr: 8'h56, data: 8'h3C});
      @(negedge clk) rst_n = 1'b1;
      wait_idle(200);
      check("post_rst_frames", frames, 32'd5);
      check("post_rst_uo_out", {24'h0, uo_out}, 32'h3C);

      // ena dropped mid-frame: frame completes, then nothing more
      expq.push_back('{addr: 8'h34, data: 8'h5A});
      ui_in = 8'h34;
      repeat (10) @(posedge clk);
      #1;
      ena = 1'b0;
      wait_idle(200);
      ui_in = 8'h12;
      repeat (100) @(posedge clk);
      #1;
      check("ena_drop_frames", frames, 32'd6);
      check("ena_drop_cs_n", {31'h0, cs_n}, 32'd1);
      check("ena_drop_uo_out", {24'h0, uo_out}, 32'h5A);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end
endmodule
